issue_queue: RTL and testbench

Parametrised in-order multi-lane issue buffer, the successor of the two-lane stall register between fetch/decode and execute. The producer enqueues up to LANES items per cycle into a circular buffer of DEPTH entries. The oldest LANES entries are presented on the output lanes. The consumer retires a contiguous prefix of them, selected by per-lane `can_proceed`, and unretired entries stay queued in order. A flush input discards all contents, e.g. on branch mispredict.

---
 rtl/issue_queue_if.sv | 16 +
 rtl/issue_queue.sv | 53 +++++
 tb/tb_issue_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// issue_queue_if: producer/consumer signals of the in-order multi-lane issue queue.
interface issue_queue_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 8
);
    logic [$clog2(LANES+1)-1:0]  in_count;
    logic [LANES-1:0][WIDTH-1:0] in;
    logic                        in_ready;
    logic [LANES-1:0][WIDTH-1:0] out;
    logic [LANES-1:0]            out_valid;
    logic [LANES-1:0]            can_proceed;
    logic [$clog2(DEPTH+1)-1:0]  count;
    modport master (output in_count, in, can_proceed, input in_ready, out, out_valid, count);
    modport slave  (input in_count, in, can_proceed, output in_ready, out, out_valid, count);
endinterface

// File: rtl/issue_queue.sv
// issue_queue: circular in-order buffer accepting and presenting up to LANES entries per cycle.
module issue_queue #(
    parameter int WIDTH = 32,
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          reset,
    input logic          flush,
    issue_queue_if.slave io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, take, acc;
    logic [LANES-1:0] valid;
    logic             rdy, run;
    always_comb begin
        rdy = CW'(DEPTH) - count_q >= CW'(LANES);
        take = '0;
        run = 1'b1;
        // retire only the unbroken prefix of accepting lanes
        for (int i = 0; i < LANES; i++) begin
            valid[i] = CW'(i) < count_q;
            io.out[i] = valid[i] ? mem_q[head_q + PW'(i)] : '0;
            run = run & valid[i] & io.can_proceed[i];
            take = take + CW'(run);
        end
        acc = !rdy ? '0 : CW'(io.in_count) > CW'(LANES) ? CW'(LANES) : CW'(io.in_count);
        head_d = head_q + PW'(take);
        tail_d = tail_q + PW'(acc);
        count_d = count_q - take + acc;
        io.out_valid = valid;
        io.in_ready = rdy;
        io.count = count_q;
    end
    always_ff @(negedge clk) begin
        if (reset || flush) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end
    always_ff @(negedge clk) begin
        for (int j = 0; j < LANES; j++)
            if (!reset && !flush && CW'(j) < acc) mem_q[tail_q + PW'(j)] <= io.in[j];
    end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed vector table on a 2-lane queue plus scoreboard runs for 1, 2 and 4 lanes.
module tb_issue_queue;
    typedef struct {
        logic        rst, fl;
        logic [2:0]  ic;
        logic [31:0] i0, i1;
        logic [3:0]  cp, cnt, vld;
        logic [31:0] o0, o1;
        logic        rdy;
    } vec_t;

    localparam int A = 'hA, B = 'hB, C = 'hC, D = 'hD, E = 'hE, F = 'hF, G = 'h10, H = 'h11;
    localparam int I = 'h12, J = 'h13, K = 'h14, L = 'h15, M = 'h16, N = 'h17, O = 'h18, P = 'h19;
    localparam int X = 'h58, Y = 'h59;

    logic             clk = 1'b0;
    logic             drv_rst [3];
    logic             drv_fl  [3];
    logic [2:0]       drv_ic  [3];
    logic [3:0][31:0] drv_in  [3];
    logic [3:0]       drv_cp  [3];
    logic [127:0]     obs_out [3];
    logic [3:0]       obs_vld [3];
    logic             obs_rdy [3];
    logic [3:0]       obs_cnt [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl [23];
    logic [31:0] q [$];
    logic [3:0][31:0] inw;
    logic [127:0] exp_out;
    logic [3:0]  exp_vld, cp;
    int unsigned nid;
    int          lanes, ic, sz, take, acc;
    bit          fl, rdy, run;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LN = 1 << g;
        localparam int IW = $clog2(LN+1);
        issue_queue_if #(.WIDTH(32), .LANES(LN), .DEPTH(8)) ifc ();
        issue_queue #(.WIDTH(32), .LANES(LN), .DEPTH(8)) dut (
            .clk(clk), .reset(drv_rst[g]), .flush(drv_fl[g]), .io(ifc)
        );
        assign ifc.in_count = drv_ic[g][IW-1:0];
        assign ifc.in = drv_in[g][LN-1:0];
        assign ifc.can_proceed = drv_cp[g][LN-1:0];
        assign obs_out[g] = 128'(ifc.out);
        assign obs_vld[g] = 4'(ifc.out_valid);
        assign obs_rdy[g] = ifc.in_ready;
        assign obs_cnt[g] = ifc.count;
    end

    function automatic vec_t v(input int rst, fl, ic, i0, i1, cp, cnt, vld, o0, o1, rdy);
        vec_t r;
        r.rst = rst[0];
        r.fl = fl[0];
        r.ic = 3'(ic);
        r.i0 = i0;
        r.i1 = i1;
        r.cp = 4'(cp);
        r.cnt = 4'(cnt);
        r.vld = 4'(vld);
        r.o0 = o0;
        r.o1 = o1;
        r.rdy = rdy[0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            drv_rst[g] = 1'b1;
            drv_fl[g] = 1'b0;
            drv_ic[g] = '0;
            drv_in[g] = '0;
            drv_cp[g] = '0;
        end
        //          rst fl ic i0 i1 cp  cnt vld o0 o1 rdy
        tbl[0]  = v(1, 0, 2, 1, 2, 3,   0, 0, 0, 0, 1);
        tbl[1]  = v(1, 0, 2, 1, 2, 3,   0, 0, 0, 0, 1);
        tbl[2]  = v(0, 0, 2, A, B, 0,   2, 3, A, B, 1);
        tbl[3]  = v(0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 1);
        tbl[4]  = v(0, 0, 2, A, B, 0,   2, 3, A, B, 1);
        tbl[5]  = v(0, 0, 1, C, 0, 0,   3, 3, A, B, 1);
        tbl[6]  = v(0, 0, 0, 0, 0, 1,   2, 3, B, C, 1);
        tbl[7]  = v(0, 0, 0, 0, 0, 2,   2, 3, B, C, 1);
        tbl[8]  = v(0, 0, 3, D, E, 0,   4, 3, B, C, 1);
        tbl[9]  = v(0, 0, 2, F, G, 0,   6, 3, B, C, 1);
        tbl[10] = v(0, 0, 2, H, I, 0,   8, 3, B, C, 0);
        tbl[11] = v(0, 0, 2, J, K, 0,   8, 3, B, C, 0);
        tbl[12] = v(0, 0, 2, J, K, 1,   7, 3, C, D, 0);
        tbl[13] = v(0, 0, 2, J, K, 3,   5, 3, E, F, 1);
        tbl[14] = v(0, 0, 2, J, K, 0,   7, 3, E, F, 0);
        tbl[15] = v(0, 0, 0, 0, 0, 1,   6, 3, F, G, 1);
        tbl[16] = v(0, 0, 2, L, M, 1,   7, 3, G, H, 0);
        tbl[17] = v(0, 0, 0, 0, 0, 3,   5, 3, I, J, 1);
        tbl[18] = v(0, 1, 2, X, Y, 3,   0, 0, 0, 0, 1);
        tbl[19] = v(0, 0, 0, 0, 0, 3,   0, 0, 0, 0, 1);
        tbl[20] = v(0, 0, 2, N, O, 0,   2, 3, N, O, 1);
        tbl[21] = v(1, 1, 2, X, Y, 3,   0, 0, 0, 0, 1);
        tbl[22] = v(0, 0, 1, P, 0, 0,   1, 1, P, 0, 1);
        @(posedge clk);
        for (int r = 0; r < 23; r++) begin
            drv_rst[1] = tbl[r].rst;
            drv_fl[1] = tbl[r].fl;
            drv_ic[1] = tbl[r].ic;
            drv_in[1] = {64'h0, tbl[r].i1, tbl[r].i0};
            drv_cp[1] = tbl[r].cp;
            @(negedge clk);
            @(posedge clk);
            chk($sformatf("row%0d_count", r), 128'(obs_cnt[1]), 128'(tbl[r].cnt));
            chk($sformatf("row%0d_valid", r), 128'(obs_vld[1]), 128'(tbl[r].vld));
            chk($sformatf("row%0d_out0", r), 128'(obs_out[1][31:0]), 128'(tbl[r].o0));
            chk($sformatf("row%0d_out1", r), 128'(obs_out[1][63:32]), 128'(tbl[r].o1));
            chk($sformatf("row%0d_ready", r), 128'(obs_rdy[1]), 128'(tbl[r].rdy));
        end
        nid = 32'h1000;
        for (int g = 0; g < 3; g++) begin
            lanes = 1 << g;
            q.delete();
            drv_rst[g] = 1'b1;
            drv_fl[g] = 1'b0;
            drv_ic[g] = 3'(lanes);
            drv_cp[g] = '1;
            @(negedge clk);
            @(posedge clk);
            chk($sformatf("l%0d_rst_count", lanes), 128'(obs_cnt[g]), 128'(0));
            chk($sformatf("l%0d_rst_valid", lanes), 128'(obs_vld[g]), 128'(0));
            chk($sformatf("l%0d_rst_ready", lanes), 128'(obs_rdy[g]), 128'(1));
            drv_rst[g] = 1'b0;
            for (int c = 0; c < 250; c++) begin
                fl = $urandom_range(0, 24) == 0;
                ic = $urandom_range(0, lanes);
                cp = 4'($urandom_range(0, 15));
                for (int j = 0; j < 4; j++) inw[j] = nid + 32'(j);
                drv_fl[g] = fl;
                drv_ic[g] = 3'(ic);
                drv_in[g] = inw;
                drv_cp[g] = cp;
                sz = q.size();
                rdy = (8 - sz) >= lanes;
                take = 0;
                run = 1'b1;
                for (int i = 0; i < lanes; i++) begin
                    run = run && (i < sz) && cp[i];
                    take += int'(run);
                end
                acc = !rdy ? 0 : (ic > lanes ? lanes : ic);
                if (fl) q.delete();
                else begin
                    repeat (take) void'(q.pop_front());
                    for (int j = 0; j < acc; j++) q.push_back(inw[j]);
                    nid += 32'(acc);
                end
                @(negedge clk);
                @(posedge clk);
                exp_out = '0;
                exp_vld = '0;
                for (int i = 0; i < lanes; i++)
                    if (i < q.size()) begin
                        exp_out[i*32 +: 32] = q[i];
                        exp_vld[i] = 1'b1;
                    end
                chk($sformatf("l%0d_c%0d_count", lanes, c), 128'(obs_cnt[g]), 128'(q.size()));
                chk($sformatf("l%0d_c%0d_valid", lanes, c), 128'(obs_vld[g]), 128'(exp_vld));
                chk($sformatf("l%0d_c%0d_out", lanes, c), obs_out[g], exp_out);
                chk($sformatf("l%0d_c%0d_ready", lanes, c), 128'(obs_rdy[g]), 128'((8 - q.size()) >= lanes));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
